// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-high glyph
// patterns (bit7..bit0 = a b c d e f g dp, dp always clear here) and a
// helper that sizes the digit index.
package seg7_pkg;

    localparam logic [7:0] GLYPH_0 = 8'hFC;
    localparam logic [7:0] GLYPH_1 = 8'h60;
    localparam logic [7:0] GLYPH_2 = 8'hDA;
    localparam logic [7:0] GLYPH_3 = 8'hF2;
    localparam logic [7:0] GLYPH_4 = 8'h66;
    localparam logic [7:0] GLYPH_5 = 8'hB6;
    localparam logic [7:0] GLYPH_6 = 8'hBE;
    localparam logic [7:0] GLYPH_7 = 8'hE0;
    localparam logic [7:0] GLYPH_8 = 8'hFE;
    localparam logic [7:0] GLYPH_9 = 8'hF6;
    localparam logic [7:0] GLYPH_A = 8'hEE;
    localparam logic [7:0] GLYPH_B = 8'h3E;
    localparam logic [7:0] GLYPH_C = 8'h9C;
    localparam logic [7:0] GLYPH_D = 8'h7A;
    localparam logic [7:0] GLYPH_E = 8'h9E;
    localparam logic [7:0] GLYPH_F = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Digit index width; a single-digit bank still needs a 1-bit index.
    function automatic int idx_width(input int num_digits);
        int w;
        w = $clog2(num_digits);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bus between the value source and the scan driver. The master
// side supplies digit values and load strobes; the slave side drives the
// segment/anode pins and the frame pulse.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   blank_i;
    logic                    lz_en_i;
    logic                    load_i;
    logic [7:0]              seg_o;
    logic [NUM_DIGITS-1:0]   an_o;
    logic                    frame_done_o;

    modport master (
        output value_i, dp_i, blank_i, lz_en_i, load_i,
        input  seg_o, an_o, frame_done_o
    );

    modport slave (
        input  value_i, dp_i, blank_i, lz_en_i, load_i,
        output seg_o, an_o, frame_done_o
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-glyph decoder; returns the a..g segments only.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_glyph
);

    // Look up the active-high a..g pattern for the hex digit
    always_comb begin
        o_glyph = SEG_OFF[7:1];
        case (i_nibble)
            4'h0:    o_glyph = GLYPH_0[7:1];
            4'h1:    o_glyph = GLYPH_1[7:1];
            4'h2:    o_glyph = GLYPH_2[7:1];
            4'h3:    o_glyph = GLYPH_3[7:1];
            4'h4:    o_glyph = GLYPH_4[7:1];
            4'h5:    o_glyph = GLYPH_5[7:1];
            4'h6:    o_glyph = GLYPH_6[7:1];
            4'h7:    o_glyph = GLYPH_7[7:1];
            4'h8:    o_glyph = GLYPH_8[7:1];
            4'h9:    o_glyph = GLYPH_9[7:1];
            4'hA:    o_glyph = GLYPH_A[7:1];
            4'hB:    o_glyph = GLYPH_B[7:1];
            4'hC:    o_glyph = GLYPH_C[7:1];
            4'hD:    o_glyph = GLYPH_D[7:1];
            4'hE:    o_glyph = GLYPH_E[7:1];
            4'hF:    o_glyph = GLYPH_F[7:1];
            default: o_glyph = SEG_OFF[7:1];
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver. Values are captured into shadow
// registers on load and only promoted to the displayed (active) set at a
// frame boundary, so a frame never mixes old and new digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 100000,
    parameter int GUARD          = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]      DIV_ONE  = DIV_W'(1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
    localparam logic [7:0]            SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                               : {NUM_DIGITS{1'b0}};

    logic [DIV_W-1:0]        r_div;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_sh_value, r_act_value;
    logic [NUM_DIGITS-1:0]   r_sh_dp, r_act_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank, r_act_blank;
    logic                    r_sh_lz, r_act_lz;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_div_end;
    logic                    w_boundary;
    logic                    w_guard;
    logic [3:0]              w_nibble;
    logic                    w_dp_bit;
    logic                    w_blank_bit;
    logic                    w_dark;
    logic                    w_run;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [6:0]              w_glyph;
    logic [7:0]              w_seg_next;
    logic [NUM_DIGITS-1:0]   w_an_next;

    assign w_div_end  = (r_div == DIV_LAST);
    assign w_boundary = w_div_end && (r_idx == IDX_LAST);

    // The first GUARD cycles of every slot keep all anodes dark
    generate
        if (GUARD > 0) begin : g_guard
            assign w_guard = (r_div < DIV_W'(GUARD));
        end else begin : g_no_guard
            assign w_guard = 1'b0;
        end
    endgenerate

    // Slot divider and digit index, wrapping at the end of the bank
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= {DIV_W{1'b0}};
            r_idx <= {IDX_W{1'b0}};
        end else if (w_div_end) begin
            r_div <= {DIV_W{1'b0}};
            r_idx <= (r_idx == IDX_LAST) ? {IDX_W{1'b0}} : r_idx + IDX_ONE;
        end else begin
            r_div <= r_div + DIV_ONE;
            r_idx <= r_idx;
        end
    end

    // Shadow capture on every load; the last load before a boundary wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh_value <= {(4*NUM_DIGITS){1'b0}};
            r_sh_dp    <= {NUM_DIGITS{1'b0}};
            r_sh_blank <= {NUM_DIGITS{1'b0}};
            r_sh_lz    <= 1'b0;
        end else if (bus.load_i) begin
            r_sh_value <= bus.value_i;
            r_sh_dp    <= bus.dp_i;
            r_sh_blank <= bus.blank_i;
            r_sh_lz    <= bus.lz_en_i;
        end
    end

    // Promote to the active set at a frame boundary; a load landing on the
    // boundary itself bypasses the shadow so it is not lost for a frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending   <= 1'b0;
            r_act_value <= {(4*NUM_DIGITS){1'b0}};
            r_act_dp    <= {NUM_DIGITS{1'b0}};
            r_act_blank <= {NUM_DIGITS{1'b0}};
            r_act_lz    <= 1'b0;
        end else if (w_boundary) begin
            r_pending <= 1'b0;
            if (bus.load_i) begin
                r_act_value <= bus.value_i;
                r_act_dp    <= bus.dp_i;
                r_act_blank <= bus.blank_i;
                r_act_lz    <= bus.lz_en_i;
            end else if (r_pending) begin
                r_act_value <= r_sh_value;
                r_act_dp    <= r_sh_dp;
                r_act_blank <= r_sh_blank;
                r_act_lz    <= r_sh_lz;
            end
        end else if (bus.load_i) begin
            r_pending <= 1'b1;
        end
    end

    // Select the current digit and work out leading-zero darkness: walking
    // down from the MSD, a digit is dark while every nibble from the MSD to
    // it is zero; digit 0 always shows
    always_comb begin
        w_nibble    = 4'h0;
        w_dp_bit    = 1'b0;
        w_blank_bit = 1'b0;
        w_dark      = 1'b0;
        w_sel       = {NUM_DIGITS{1'b0}};
        w_run       = r_act_lz;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_run = w_run && (r_act_value[4*k +: 4] == 4'h0);
            if (r_idx == IDX_W'(k)) begin
                w_nibble    = r_act_value[4*k +: 4];
                w_dp_bit    = r_act_dp[k];
                w_blank_bit = r_act_blank[k];
                w_dark      = w_run && (k != 0);
                w_sel[k]    = 1'b1;
            end else begin
                w_sel[k]    = 1'b0;
            end
        end
    end

    seg7_hex_decode u_dec (
        .i_nibble (w_nibble),
        .o_glyph  (w_glyph)
    );

    // Active-high segment/anode pattern; blank beats suppression and dp
    always_comb begin
        w_seg_next = SEG_OFF;
        w_an_next  = {NUM_DIGITS{1'b0}};
        if (w_guard) begin
            w_seg_next = SEG_OFF;
            w_an_next  = {NUM_DIGITS{1'b0}};
        end else if (w_blank_bit) begin
            w_seg_next = SEG_OFF;
            w_an_next  = w_sel;
        end else begin
            w_seg_next = {(w_dark ? 7'h00 : w_glyph), w_dp_bit};
            w_an_next  = w_sel;
        end
    end

    // Output registers; pin polarity is applied only here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg        <= SEG_IDLE;
            r_an         <= AN_IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= SEG_ACTIVE_LOW ? ~w_seg_next : w_seg_next;
            r_an         <= AN_ACTIVE_LOW ? ~w_an_next : w_an_next;
            r_frame_done <= w_boundary;
        end
    end

    assign bus.seg_o        = r_seg;
    assign bus.an_o         = r_an;
    assign bus.frame_done_o = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two 4-digit instances (normal and inverted
// polarity) share stimulus. A cycle model pushes expected outputs into a
// scoreboard queue; a table of display patterns with hand-derived glyphs
// and a few timed sequences cover buffering, collisions and reset.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int GD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp, blank;
    logic        lz, load;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus_a ();
    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus_b ();

    assign bus_a.value_i = value;  assign bus_b.value_i = value;
    assign bus_a.dp_i    = dp;     assign bus_b.dp_i    = dp;
    assign bus_a.blank_i = blank;  assign bus_b.blank_i = blank;
    assign bus_a.lz_en_i = lz;     assign bus_b.lz_en_i = lz;
    assign bus_a.load_i  = load;   assign bus_b.load_i  = load;

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD),
                       .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (bus_a));

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD),
                       .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b0)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (bus_b));

    always #5 clk = ~clk;

    // ---------------- reference model + scoreboard ----------------
    logic [7:0] GLY [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    typedef struct packed {
        logic [7:0] seg_a;
        logic [3:0] an_a;
        logic [7:0] seg_b;
        logic [3:0] an_b;
        logic       fd;
    } exp_t;

    exp_t sb_q [$];

    int          m_div = 0, m_idx = 0;
    logic        m_pend = 1'b0;
    logic [15:0] m_sh_val = 16'h0, m_act_val = 16'h0;
    logic [3:0]  m_sh_dp = 4'h0, m_act_dp = 4'h0, m_sh_bl = 4'h0, m_act_bl = 4'h0;
    logic        m_sh_lz = 1'b0, m_act_lz = 1'b0;

    function automatic exp_t model_out();
        exp_t       e;
        int         nib;
        logic       dark;
        logic [7:0] s;
        logic [3:0] a;
        nib  = int'(m_act_val[4*m_idx +: 4]);
        dark = m_act_lz && (m_idx != 0);
        for (int k = m_idx; k < ND; k++)
            if (m_act_val[4*k +: 4] != 4'h0) dark = 1'b0;
        if (m_act_bl[m_idx]) s = 8'h00;
        else s = (dark ? 8'h00 : GLY[nib]) | {7'b0, m_act_dp[m_idx]};
        if (m_div < GD) begin
            s = 8'h00;
            a = 4'h0;
        end else begin
            a = 4'b0001 << m_idx;
        end
        e.seg_a = s;  e.an_a = ~a;
        e.seg_b = ~s; e.an_b = a;
        e.fd    = (m_div == SD - 1) && (m_idx == ND - 1);
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            sb_q.push_back('{8'h00, 4'hF, 8'hFF, 4'h0, 1'b0});
            m_div <= 0; m_idx <= 0; m_pend <= 1'b0;
            m_sh_val <= 16'h0; m_sh_dp <= 4'h0; m_sh_bl <= 4'h0; m_sh_lz <= 1'b0;
            m_act_val <= 16'h0; m_act_dp <= 4'h0; m_act_bl <= 4'h0; m_act_lz <= 1'b0;
        end else begin
            sb_q.push_back(model_out());
            m_div <= (m_div == SD - 1) ? 0 : m_div + 1;
            m_idx <= (m_div == SD - 1) ? (m_idx + 1) % ND : m_idx;
            if (load) begin
                m_sh_val <= value; m_sh_dp <= dp; m_sh_bl <= blank; m_sh_lz <= lz;
            end
            if (m_div == SD - 1 && m_idx == ND - 1) begin
                m_pend <= 1'b0;
                if (load) begin
                    m_act_val <= value; m_act_dp <= dp; m_act_bl <= blank; m_act_lz <= lz;
                end else if (m_pend) begin
                    m_act_val <= m_sh_val; m_act_dp <= m_sh_dp;
                    m_act_bl <= m_sh_bl;   m_act_lz <= m_sh_lz;
                end
            end else if (load) begin
                m_pend <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            chk("sb_seg_a", bus_a.seg_o, sb_q[0].seg_a);
            chk("sb_an_a", {4'h0, bus_a.an_o}, {4'h0, sb_q[0].an_a});
            chk("sb_fd_a", {7'h0, bus_a.frame_done_o}, {7'h0, sb_q[0].fd});
            chk("sb_seg_b", bus_b.seg_o, sb_q[0].seg_b);
            chk("sb_an_b", {4'h0, bus_b.an_o}, {4'h0, sb_q[0].an_b});
            sb_q.delete(0);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_fd(input string tag);
        int k;
        k = 0;
        while (bus_a.frame_done_o !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_fd_seen"}, {7'h0, bus_a.frame_done_o}, 8'h01);
    endtask

    // Called on the negedge where frame_done is seen; samples mid-slot
    task automatic check_frame(input logic [31:0] ex, input string tag);
        logic [7:0] g;
        logic [3:0] oh, oh_n;
        repeat (5) @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            g    = ex[8*k +: 8];
            oh   = 4'b0001 << k;
            oh_n = ~oh;
            chk($sformatf("%s_d%0d_seg_a", tag, k), bus_a.seg_o, g);
            chk($sformatf("%s_d%0d_an_a", tag, k), {4'h0, bus_a.an_o}, {4'h0, oh_n});
            chk($sformatf("%s_d%0d_seg_b", tag, k), bus_b.seg_o, ~g);
            chk($sformatf("%s_d%0d_an_b", tag, k), {4'h0, bus_b.an_o}, {4'h0, oh});
            if (k < ND - 1) repeat (SD) @(negedge clk);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_seg_a"}, bus_a.seg_o, 8'h00);
        chk({tag, "_an_a"}, {4'h0, bus_a.an_o}, 8'h0F);
        chk({tag, "_fd_a"}, {7'h0, bus_a.frame_done_o}, 8'h00);
        chk({tag, "_seg_b"}, bus_b.seg_o, 8'hFF);
        chk({tag, "_an_b"}, {4'h0, bus_b.an_o}, 8'h00);
    endtask

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dpv;
        logic [3:0]  blk;
        logic        lzv;
        logic [31:0] exp;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [7];

    initial begin
        int cnt;
        vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, {8'h60, 8'hDA, 8'hF2, 8'h66}};
        vecs[1] = '{16'hABCD, 4'b0000, 4'b0000, 1'b0, {8'hEE, 8'h3E, 8'h9C, 8'h7A}};
        vecs[2] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, {8'h00, 8'h00, 8'hB6, 8'hFC}};
        vecs[3] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {8'h00, 8'h00, 8'h00, 8'hFC}};
        vecs[4] = '{16'h8888, 4'b0010, 4'b0100, 1'b0, {8'hFE, 8'h00, 8'hFF, 8'hFE}};
        vecs[5] = '{16'h0007, 4'b1000, 4'b0000, 1'b1, {8'h01, 8'h00, 8'h00, 8'hE0}};
        vecs[6] = '{16'h1020, 4'b0000, 4'b0000, 1'b1, {8'h60, 8'hFC, 8'hDA, 8'hFC}};

        rst_n = 1'b0; value = 16'h0; dp = 4'h0; blank = 4'h0; lz = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        // Table-driven display patterns
        for (int i = 0; i < 7; i++) begin
            value = vecs[i].val; dp = vecs[i].dpv; blank = vecs[i].blk; lz = vecs[i].lzv;
            load  = 1'b1;
            @(negedge clk);
            load  = 1'b0;
            wait_fd($sformatf("v%0d", i));
            check_frame(vecs[i].exp, $sformatf("v%0d", i));
        end

        // Double buffering: load during digit 1, old value persists this frame
        wait_fd("dbuf_start");
        repeat (10) @(negedge clk);
        value = 16'hABCD; dp = 4'h0; blank = 4'h0; lz = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(negedge clk);
        chk("dbuf_old_d2", bus_a.seg_o, 8'hFC);
        repeat (8) @(negedge clk);
        chk("dbuf_old_d3", bus_a.seg_o, 8'h60);
        wait_fd("dbuf_new");
        check_frame({8'hEE, 8'h3E, 8'h9C, 8'h7A}, "dbuf_new");

        // Frame pulse period
        wait_fd("period_start");
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus_a.frame_done_o !== 1'b1 && cnt < 100);
        chk("fd_period", cnt[7:0], 8'd32);

        // Load on the boundary cycle shows in the very next slot
        repeat (31) @(negedge clk);
        value = 16'h0009; dp = 4'h0; blank = 4'h0; lz = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("coll_fd", {7'h0, bus_a.frame_done_o}, 8'h01);
        check_frame({8'hFC, 8'hFC, 8'hFC, 8'hF6}, "coll");

        // Reset mid-slot discards a pending load
        wait_fd("rst_start");
        repeat (3) @(negedge clk);
        value = 16'h5555; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("mid_reset");
        rst_n = 1'b1;
        wait_fd("post_rst");
        check_frame({8'hFC, 8'hFC, 8'hFC, 8'hFC}, "post_rst");

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
